mux_arbiter_2ch: RTL and testbench
==================================

MUX_ARBITER_2CH -- requirements
Module: mux_arbiter_2ch

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning data MSB index (data width N+1).
REQ-002 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles while the other requester waits.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0 / req1  input  1  requests from requesters 0 and 1.
REQ-006 The block SHALL have ports I0 / I1  input  N+1  data from requesters 0 and 1.
REQ-007 The block SHALL have ports gnt0 / gnt1  output  1  registered grants, one-hot or zero.
REQ-008 The block SHALL have port out  output  N+1  registered selected data.
REQ-009 The block SHALL have port out_valid  output  1  out holds granted data.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT0 and GRANT1, and gnt0/gnt1 SHALL be decoded from state only (Moore).
REQ-011 In IDLE, a single active request SHALL move the FSM to the matching GRANTx on the next edge; with no requests the FSM SHALL stay in IDLE.
REQ-012 In IDLE with req0 and req1 both high, the FSM SHALL grant the requester not recorded in last_served.
REQ-013 On every entry to GRANTx, last_served SHALL be set to x and hold_cnt SHALL be set to 1.
REQ-014 In GRANTx with reqx high, and the timeout (REQ-015) not met, the FSM SHALL stay in GRANTx and increment hold_cnt, saturating at MAX_HOLD.
REQ-015 In GRANTx, when hold_cnt == MAX_HOLD and the other request is high, the FSM SHALL move directly to the other GRANT state with no IDLE cycle, even if reqx is still high.
REQ-016 In GRANTx with reqx low, the FSM SHALL move to the other GRANT state if the other request is high, else to IDLE.
REQ-017 The datapath select SHALL be sel = (state == GRANT1), applied through a 2:1 (N+1)-bit mux.
REQ-018 Each edge with the FSM in a GRANT state SHALL register out <= mux(I0, I1, sel) and out_valid <= 1; data sampled during a grant cycle SHALL appear on out one cycle later.
REQ-019 Each edge with the FSM in IDLE SHALL register out <= 0 and out_valid <= 0.
REQ-020 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-021 A request dropped and re-raised while not granted SHALL carry no memory: arbitration uses only current req values and last_served.

Reset
REQ-022 rst_n low SHALL immediately set state = IDLE, gnt0 = gnt1 = 0, out = 0, out_valid = 0, hold_cnt = 0 and last_served = 1, so req0 wins the first tie.
REQ-023 Reset asserted mid-grant SHALL abort the grant without completing the current transfer; the first grant after release SHALL follow the post-reset last_served value.

Configuration
REQ-024 Macro ARB_HOLD_TIMEOUT_EN defined SHALL compile in hold_cnt and the REQ-015 forced rotation.
REQ-025 Without ARB_HOLD_TIMEOUT_EN, hold_cnt SHALL be absent and a grant SHALL be held until its request drops; MAX_HOLD SHALL be ignored.

Structure
REQ-026 Shared package arb_pkg SHALL hold the state encoding constants (IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10) and the default N and MAX_HOLD values.
REQ-027 The 2:1 datapath SHALL be the sub-module mux_n_bits: combinational, parameter N, ports out, I0, I1, sel.
REQ-028 The hold counter width SHALL be $clog2(MAX_HOLD + 1).

Verification
REQ-029 Reset release with req0 = req1 = 1 -> gnt0 = 1 at the first edge; out_valid = 1 with out = I0 one edge later.
REQ-030 req1 alone, I1 = 3'b110 -> gnt1 at edge 1, out = 3'b110 with out_valid = 1 at edge 2; req1 dropped -> IDLE, out = 0 and out_valid = 0 one edge later.
REQ-031 Both requests held continuously, MAX_HOLD = 4, timeout enabled -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating with no idle gap.
REQ-032 Same stimulus with ARB_HOLD_TIMEOUT_EN undefined -> gnt0 held indefinitely; req0 dropped -> gnt1 on the next edge.
REQ-033 rst_n pulsed low during GRANT1 -> gnt1, out and out_valid go to 0 asynchronously; after release with both requests high, gnt0 is granted first.
REQ-034 Every cycle of all scenarios -> assertion gnt0 & gnt1 == 0 holds.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the two-channel arbitrating mux: state encoding
// and default parameter values.
package arb_pkg;

    localparam int unsigned ARB_N_DEFAULT        = 2;
    localparam int unsigned ARB_MAX_HOLD_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/mux_n_bits.sv
// Combinational 2:1 mux of (N+1)-bit words; sel high picks I1.
module mux_n_bits
    import arb_pkg::*;
#(
    parameter int unsigned N = ARB_N_DEFAULT
) (
    output logic [N:0] out,
    input  logic [N:0] I0,
    input  logic [N:0] I1,
    input  logic       sel
);

    assign out = sel ? I1 : I0;

endmodule : mux_n_bits

// File: rtl/mux_arbiter_2ch.sv
// Two-requester round-robin arbiter with a registered data mux.
// Grants are Moore-decoded from the state register; out/out_valid lag the
// grant by one cycle. Define ARB_HOLD_TIMEOUT_EN to force a hand-over after
// MAX_HOLD consecutive grant cycles while the other side is waiting.
module mux_arbiter_2ch
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N_DEFAULT,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [N:0] I0,
    input  logic [N:0] I1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [N:0] out,
    output logic       out_valid
);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic       r_last_served;
    logic       w_hold_full;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_sel;
    logic       w_in_grant;
    logic [N:0] w_mux_out;
    logic [N:0] r_out;
    logic       r_out_valid;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold_cnt;

    assign w_hold_full = (r_hold_cnt == HOLD_W'(MAX_HOLD));

    // Consecutive-grant counter: 1 on entry to a grant, saturating while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_state_next == IDLE) begin
            r_hold_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_hold_cnt <= HOLD_W'(1);
        end else if (!w_hold_full) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end
`else
    // No forced rotation: MAX_HOLD has no effect and this term folds to zero.
    assign w_hold_full = (MAX_HOLD != 0) & 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: ties go to the side not served last; timeout hands over directly.
    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_state_next = r_last_served ? GRANT0 : GRANT1;
                end else if (req0) begin
                    w_state_next = GRANT0;
                end else if (req1) begin
                    w_state_next = GRANT1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            GRANT0: begin
                if (w_hold_full && req1) begin
                    w_state_next = GRANT1;
                end else if (req0) begin
                    w_state_next = GRANT0;
                end else if (req1) begin
                    w_state_next = GRANT1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            GRANT1: begin
                if (w_hold_full && req0) begin
                    w_state_next = GRANT0;
                end else if (req1) begin
                    w_state_next = GRANT1;
                end else if (req0) begin
                    w_state_next = GRANT0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Moore output decode from the current state.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_gnt0     = (r_state == GRANT0);
        w_gnt1     = (r_state == GRANT1);
        w_sel      = w_gnt1;
        w_in_grant = w_gnt0 | w_gnt1;
    end

    // Record which requester was most recently granted, on grant entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_served <= 1'b1;
        end else if ((w_state_next == GRANT0) && (r_state != GRANT0)) begin
            r_last_served <= 1'b0;
        end else if ((w_state_next == GRANT1) && (r_state != GRANT1)) begin
            r_last_served <= 1'b1;
        end
    end

    mux_n_bits #(
        .N (N)
    ) u_mux (
        .out (w_mux_out),
        .I0  (I0),
        .I1  (I1),
        .sel (w_sel)
    );

    // Register the selected word while granted; clear it while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_in_grant) begin
            r_out       <= w_mux_out;
            r_out_valid <= 1'b1;
        end else begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule : mux_arbiter_2ch

// File: tb/tb_mux_arbiter_2ch.sv
// Directed self-checking bench for mux_arbiter_2ch (N = 2, MAX_HOLD = 4).
// Hold-timeout expectations follow ARB_HOLD_TIMEOUT_EN when it is defined.
module tb_mux_arbiter_2ch;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [2:0] I0;
    logic [2:0] I1;
    logic       gnt0;
    logic       gnt1;
    logic [2:0] out;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    mux_arbiter_2ch #(
        .N        (2),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .I0        (I0),
        .I1        (I1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grants must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        checks++;
        if ((gnt0 & gnt1) !== 1'b0) begin
            errors++;
            $display("FAIL onehot: gnt0=%b gnt1=%b at %0t", gnt0, gnt1, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        I0    = 3'b000;
        I1    = 3'b000;
        tick();
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
        end
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: out=%b valid=%b exp 000 0", out, out_valid);
        end
    endtask

    task automatic test_first_tie();
        req0  = 1'b1;
        req1  = 1'b1;
        I0    = 3'b011;
        I1    = 3'b100;
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_tie_gnt: gnt0=%b gnt1=%b valid=%b exp 1 0 0", gnt0, gnt1, out_valid);
        end
        tick();
        checks++;
        if (out !== 3'b011 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_tie_out: out=%b valid=%b exp 011 1", out, out_valid);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL first_tie_idle: gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
        end
        tick();
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_tie_clear: out=%b valid=%b exp 000 0", out, out_valid);
        end
    endtask

    task automatic test_single_req1();
        I0   = 3'b001;
        I1   = 3'b110;
        req1 = 1'b1;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL req1_gnt: gnt0=%b gnt1=%b valid=%b exp 0 1 0", gnt0, gnt1, out_valid);
        end
        tick();
        checks++;
        if (out !== 3'b110 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL req1_out: out=%b valid=%b exp 110 1", out, out_valid);
        end
        I1 = 3'b010;
        tick();
        checks++;
        if (out !== 3'b010 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL req1_track: out=%b valid=%b exp 010 1", out, out_valid);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (gnt1 !== 1'b0 || out !== 3'b010 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL req1_drop: gnt1=%b out=%b valid=%b exp 0 010 1", gnt1, out, out_valid);
        end
        tick();
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL req1_idle_out: out=%b valid=%b exp 000 0", out, out_valid);
        end
    endtask

    task automatic test_hold();
        logic       exp_g0;
        logic       exp_g1;
        logic       prev_g1;
        logic [2:0] exp_out;
        I0      = 3'b001;
        I1      = 3'b111;
        req0    = 1'b1;
        req1    = 1'b1;
        prev_g1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef ARB_HOLD_TIMEOUT_EN
            exp_g1 = ((((k - 1) / 4) % 2) == 1);
`else
            exp_g1 = 1'b0;
`endif
            exp_g0 = ~exp_g1;
            checks++;
            if (gnt0 !== exp_g0 || gnt1 !== exp_g1) begin
                errors++;
                $display("FAIL hold_gnt[%0d]: gnt0=%b gnt1=%b exp %b %b", k, gnt0, gnt1, exp_g0, exp_g1);
            end
            if (k > 1) begin
                exp_out = prev_g1 ? 3'b111 : 3'b001;
                checks++;
                if (out !== exp_out || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_out[%0d]: out=%b valid=%b exp %b 1", k, out, out_valid, exp_out);
                end
            end
            prev_g1 = exp_g1;
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL hold_handover: gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        I1   = 3'b101;
        req1 = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt1 !== 1'b1 || out !== 3'b101 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: gnt1=%b out=%b valid=%b exp 1 101 1", gnt1, out, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt1 !== 1'b0 || out !== 3'b000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: gnt1=%b out=%b valid=%b exp 0 000 0", gnt1, out, out_valid);
        end
        req0 = 1'b1;
        I0   = 3'b010;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold: gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_first: gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1);
        end
    endtask

    task automatic test_tie_rotation();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL rot_idle: gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL rot_tie: gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt1 !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rot_end: gnt1=%b valid=%b exp 0 0", gnt1, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_tie();
        test_single_req1();
        test_hold();
        test_reset_mid_grant();
        test_tie_rotation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_arbiter_2ch
